// File: rtl/clock_monitor_pkg.sv
// ---------------------------------------------------------------------------
// clock_monitor_pkg
// Shared types and helpers for the burst-clock monitor.
//   state_e    : FSM state encoding (IDLE, WAIT_FIRST, MEASURE, DONE)
//   COUNT_MAX  : all-ones value of the widest supported counter (64 bits)
//   count_max  : all-ones value for a counter of a given width
//   sat_inc    : saturating increment for a counter of a given width
// No ports; imported by clock_burst_monitor.
// ---------------------------------------------------------------------------
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    DONE       = 2'd3
  } state_e;

  localparam logic [63:0] COUNT_MAX = '1;

  // Counters narrower than 64 bits saturate at their own all-ones value,
  // so the mask is derived from the widest one by shifting.
  function automatic logic [63:0] count_max(input int unsigned w);
    if (w >= 64) begin
      return COUNT_MAX;
    end
    return COUNT_MAX >> (64 - w);
  endfunction

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    m = count_max(w);
    return (v >= m) ? m : v + 64'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous strobe into the clk_i domain through STAGES
// synchronizer flops (STAGES >= 2), then one extra flop for edge detection.
// Ports:
//   clk_i   : sampling clock
//   rst_ni  : asynchronous active-low reset, clears every flop
//   async_i : asynchronous input
//   level_o : synchronized level (s)
//   rise_o  : one-cycle pulse, s & ~s_d
//   fall_o  : one-cycle pulse, ~s & s_d
// ---------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift chain for metastability settling, plus the delayed copy of the
  // settled level used to spot transitions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/clock_burst_monitor.sv
// ---------------------------------------------------------------------------
// clock_burst_monitor
// Measures an incoming burst clock in the I_CLK domain: rising-to-rising
// period, rising-to-falling high time and rising-edge count. The result is
// reported when the burst ends through I_ENABLE dropping or an idle timeout.
// Optional build macro: CLKMON_JITTER_CHECK_EN enables the period jitter
// check that drives O_ERROR; without it O_ERROR is tied low.
// Ports:
//   I_CLK         : system clock
//   I_RSTn        : asynchronous active-low reset
//   I_ENABLE      : arm/run, level sensitive
//   I_CLK_IN      : monitored clock, asynchronous to I_CLK
//   I_TIMEOUT     : idle cycles without a rise that end a burst, 0 = never
//   O_BUSY        : high in WAIT_FIRST and MEASURE
//   O_DONE        : result valid, held until I_ENABLE goes low
//   O_PERIOD      : last captured rising-to-rising interval
//   O_HIGH_TIME   : last captured rising-to-falling interval
//   O_PULSE_COUNT : rising edges seen in the current burst
//   O_ERROR       : sticky jitter flag
// All counters are COUNT_W bits wide (at most 64).
// ---------------------------------------------------------------------------
module clock_burst_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned JITTER_TOL  = 1
) (
  input  logic               I_CLK,
  input  logic               I_RSTn,
  input  logic               I_ENABLE,
  input  logic               I_CLK_IN,
  input  logic [COUNT_W-1:0] I_TIMEOUT,
  output logic               O_BUSY,
  output logic               O_DONE,
  output logic [COUNT_W-1:0] O_PERIOD,
  output logic [COUNT_W-1:0] O_HIGH_TIME,
  output logic [COUNT_W-1:0] O_PULSE_COUNT,
  output logic               O_ERROR
);

  localparam logic [COUNT_W-1:0] CntOne = COUNT_W'(1);

  logic s;
  logic rise;
  logic fall;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] c_q, c_d;
  logic [COUNT_W-1:0] h_q, h_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0] high_q, high_d;
  logic [COUNT_W-1:0] pulses_q, pulses_d;
  logic [COUNT_W-1:0] c_inc;
  logic [COUNT_W-1:0] h_inc;
  logic [COUNT_W-1:0] pulses_inc;
  logic               timeout_en;
  logic               arm;
  logic               capture;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (I_CLK),
    .rst_ni  (I_RSTn),
    .async_i (I_CLK_IN),
    .level_o (s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  assign c_inc      = COUNT_W'(sat_inc(64'(c_q), COUNT_W));
  assign h_inc      = COUNT_W'(sat_inc(64'(h_q), COUNT_W));
  assign pulses_inc = COUNT_W'(sat_inc(64'(pulses_q), COUNT_W));
  assign timeout_en = (I_TIMEOUT != '0);

  // Arming and period capture are shared with the optional jitter checker,
  // so they are decoded once here.
  assign arm     = (state_q == IDLE) && I_ENABLE;
  assign capture = (state_q == MEASURE) && I_ENABLE && rise;

  // Next-state and result logic. The edge-detect latency is the same for
  // every edge, so intervals are measured directly on the synchronized
  // rise/fall pulses. In WAIT_FIRST the timeout fires when the idle count
  // c reaches I_TIMEOUT (its next value), so DONE arrives exactly I_TIMEOUT
  // cycles after arming. In MEASURE the registered interval c is compared,
  // which lets a rise landing on c == I_TIMEOUT still be counted.
  always_comb begin
    state_d  = state_q;
    c_d      = rise ? CntOne : c_inc;
    h_d      = rise ? CntOne : (s ? h_inc : h_q);
    period_d = period_q;
    high_d   = high_q;
    pulses_d = pulses_q;

    case (state_q)
      IDLE: begin
        if (I_ENABLE) begin
          state_d  = WAIT_FIRST;
          c_d      = '0;
          period_d = '0;
          high_d   = '0;
          pulses_d = '0;
        end
      end

      WAIT_FIRST: begin
        if (!I_ENABLE) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d  = MEASURE;
          pulses_d = CntOne;
        end else if (timeout_en && (c_inc >= I_TIMEOUT)) begin
          state_d = DONE;
        end
      end

      MEASURE: begin
        if (!I_ENABLE) begin
          state_d = IDLE;
        end else begin
          if (rise) begin
            period_d = c_q;
            pulses_d = pulses_inc;
          end
          if (fall) begin
            high_d = h_q;
          end
          if (!rise && timeout_en && (c_q >= I_TIMEOUT)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (!I_ENABLE) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and result registers.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q  <= IDLE;
      c_q      <= '0;
      h_q      <= '0;
      period_q <= '0;
      high_q   <= '0;
      pulses_q <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      h_q      <= h_d;
      period_q <= period_d;
      high_q   <= high_d;
      pulses_q <= pulses_d;
    end
  end

`ifdef CLKMON_JITTER_CHECK_EN
  logic [COUNT_W-1:0] p0_q, p0_d;
  logic               p0_valid_q, p0_valid_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] diff;

  assign diff = (c_q >= p0_q) ? (c_q - p0_q) : (p0_q - c_q);

  // The first period of a burst becomes the reference; every later capture
  // that strays from it by more than JITTER_TOL raises a sticky error that
  // only re-arming clears.
  always_comb begin
    p0_d       = p0_q;
    p0_valid_d = p0_valid_q;
    err_d      = err_q;
    if (arm) begin
      p0_d       = '0;
      p0_valid_d = 1'b0;
      err_d      = 1'b0;
    end else if (capture) begin
      if (!p0_valid_q) begin
        p0_d       = c_q;
        p0_valid_d = 1'b1;
      end else if (diff > COUNT_W'(JITTER_TOL)) begin
        err_d = 1'b1;
      end
    end
  end

  // Jitter reference and sticky error flag.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      p0_q       <= '0;
      p0_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      p0_q       <= p0_d;
      p0_valid_q <= p0_valid_d;
      err_q      <= err_d;
    end
  end

  assign O_ERROR = err_q;
`else
  logic unused_jitter;
  assign unused_jitter = arm ^ capture ^ (JITTER_TOL != 0);
  assign O_ERROR       = 1'b0;
`endif

  assign O_BUSY        = (state_q == WAIT_FIRST) || (state_q == MEASURE);
  assign O_DONE        = (state_q == DONE);
  assign O_PERIOD      = period_q;
  assign O_HIGH_TIME   = high_q;
  assign O_PULSE_COUNT = pulses_q;

endmodule
